// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: request sequencer, in-order response FIFO, redirect discard.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched/perf_discarded counters.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_instr_q [FIFO_DEPTH];
    logic [31:0]   r_pc_q    [FIFO_DEPTH];

    logic          w_req_fire;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW:0]   w_occupancy;
    logic [31:0]   w_redirect_tgt;

    assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign w_occupancy    = {1'b0, r_count} + {1'b0, r_inflight};

    assign mem_req_valid = !reset && !redirect_valid
                        && (r_inflight < CW'(MAX_OUTSTANDING))
                        && (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign mem_req_addr  = r_fetch_pc;

    assign w_req_fire = mem_req_valid && mem_req_ready;
    // responses with nothing outstanding are stray and ignored entirely
    assign w_rsp      = mem_rsp_valid && (r_inflight != '0);
    assign w_drop     = w_rsp && (redirect_valid || (r_discard != '0));
    assign w_push     = w_rsp && !w_drop;
    assign w_pop      = out_valid && out_ready;

    assign w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_rsp);

    assign out_valid = (r_count != '0) && !redirect_valid;
    assign out_instr = r_instr_q[r_rd_ptr];
    assign out_pc    = r_pc_q[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            r_rsp_pc   <= RESET_PC & 32'hFFFF_FFFC;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                // everything still in flight belongs to the old path
                r_fetch_pc <= w_redirect_tgt;
                r_rsp_pc   <= w_redirect_tgt;
                r_discard  <= w_inflight_nxt;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_rsp && (r_discard != '0))
                    r_discard <= r_discard - CW'(1);
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= mem_rsp_data;
            r_pc_q[r_wr_ptr]    <= r_rsp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched   <= '0;
            r_perf_discarded <= '0;
        end else begin
            if (w_push)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_drop)
                r_perf_discarded <= r_perf_discarded + 32'd1;
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a 1- or 2-cycle memory model.
module tb_riscv_fetch_unit;

    localparam logic [31:0] K = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    logic        lat2 = 1'b0;
    logic        s1_v, s2_v;
    logic [31:0] s1_a, s2_a;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    always #5 clk = ~clk;

    // memory returns addr ^ K, in order, 1 or 2 cycles after acceptance
    always @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s1_a <= 32'h0;
            s2_a <= 32'h0;
        end else begin
            s1_v <= mem_req_valid && mem_req_ready;
            s1_a <= mem_req_addr;
            s2_v <= s1_v;
            s2_a <= s1_a;
        end
    end

    assign mem_rsp_valid = lat2 ? s2_v : s1_v;
    assign mem_rsp_data  = (lat2 ? s2_a : s1_a) ^ K;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_req_valid", 32'(mem_req_valid), 32'h1);
        chk("first_req_addr", mem_req_addr, 32'h0);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // streaming fill, 1-cycle memory
        lat2 = 1'b0;
        mem_req_ready = 1'b1;
        out_ready = 1'b1;
        do_reset();
        cyc(); chk("c1_addr", mem_req_addr, 32'h4);
        chk("c1_out_valid", 32'(out_valid), 32'h0);
        cyc(); chk("c2_out_valid", 32'(out_valid), 32'h1);
        chk("c2_pc", out_pc, 32'h0);
        chk("c2_instr", out_instr, 32'h0 ^ K);
        cyc(); chk("c3_pc", out_pc, 32'h4);
        cyc(); chk("c4_pc", out_pc, 32'h8);
        cyc(); chk("c5_pc", out_pc, 32'hC);
        chk("c5_instr", out_instr, 32'hC ^ K);

        // redirect with response and out handshake in the same cycle
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("rd1_out_valid", 32'(out_valid), 32'h0);
        chk("rd1_req_valid", 32'(mem_req_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rd1_n1_empty", 32'(out_valid), 32'h0);
        chk("rd1_n1_addr", mem_req_addr, 32'h200);
        chk("rd1_n1_req_valid", 32'(mem_req_valid), 32'h1);
        cyc(); chk("rd1_n2_out_valid", 32'(out_valid), 32'h0);
        cyc(); chk("rd1_n3_out_valid", 32'(out_valid), 32'h1);
        chk("rd1_n3_pc", out_pc, 32'h200);
        cyc(); chk("rd1_n4_pc", out_pc, 32'h204);

        // back-to-back redirects, last wins, unaligned target
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        #1;
        chk("rd2_req_valid", 32'(mem_req_valid), 32'h0);
        @(negedge clk);
        redirect_pc = 32'h103;
        #1;
        chk("rd3_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rd3_addr", mem_req_addr, 32'h100);
        chk("rd3_out_valid_n1", 32'(out_valid), 32'h0);
        cyc(); chk("rd3_out_valid_n2", 32'(out_valid), 32'h0);
        cyc(); chk("rd3_pc", out_pc, 32'h100);
        chk("rd3_instr", out_instr, 32'h100 ^ K);

        // address wrap at the top of memory
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        #1;
        chk("wr_req_valid", 32'(mem_req_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("wr_addr_top", mem_req_addr, 32'hFFFF_FFFC);
        cyc(); chk("wr_addr_zero", mem_req_addr, 32'h0);
        cyc(); chk("wr_pc_top", out_pc, 32'hFFFF_FFFC);
        cyc(); chk("wr_pc_zero", out_pc, 32'h0);

        // memory stall holds the request address
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("st_addr0", mem_req_addr, 32'hC);
        cyc(); chk("st_addr1", mem_req_addr, 32'hC);
        chk("st_pc", out_pc, 32'h8);
        @(negedge clk);
        mem_req_ready = 1'b1;
        #1;
        chk("st_out_valid", 32'(out_valid), 32'h0);
        chk("st_req_valid", 32'(mem_req_valid), 32'h1);
        cyc(); chk("st_addr_next", mem_req_addr, 32'h10);
        cyc(); chk("st_pc_after", out_pc, 32'hC);

        // FIFO full with decode stalled, then drain
        out_ready = 1'b0;
        do_reset();
        repeat (6) cyc();
        chk("full_out_valid", 32'(out_valid), 32'h1);
        chk("full_req_valid", 32'(mem_req_valid), 32'h0);
        chk("full_pc", out_pc, 32'h0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("dr0_pc", out_pc, 32'h0);
        chk("dr0_req_valid", 32'(mem_req_valid), 32'h0);
        cyc(); chk("dr1_pc", out_pc, 32'h4);
        chk("dr1_addr", mem_req_addr, 32'h10);
        cyc(); chk("dr2_pc", out_pc, 32'h8);
        cyc(); chk("dr3_pc", out_pc, 32'hC);
        cyc(); chk("dr4_pc", out_pc, 32'h10);

        // redirect with two requests in flight, 2-cycle memory
        lat2 = 1'b1;
        do_reset();
        cyc(); chk("l2_c1_addr", mem_req_addr, 32'h4);
        chk("l2_c1_req_valid", 32'(mem_req_valid), 32'h1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("l2_rd_out_valid", 32'(out_valid), 32'h0);
        chk("l2_rd_req_valid", 32'(mem_req_valid), 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("l2_n1_addr", mem_req_addr, 32'h100);
        chk("l2_n1_out_valid", 32'(out_valid), 32'h0);
        cyc(); chk("l2_n2_out_valid", 32'(out_valid), 32'h0);
        cyc(); chk("l2_n3_out_valid", 32'(out_valid), 32'h0);
        chk("l2_n3_req_limit", 32'(mem_req_valid), 32'h0);
        cyc(); chk("l2_n4_out_valid", 32'(out_valid), 32'h1);
        chk("l2_n4_pc", out_pc, 32'h100);
        chk("l2_n4_instr", out_instr, 32'h100 ^ K);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_discarded", perf_discarded, 32'd2);
        chk("perf_fetched", perf_fetched, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
